mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the register-file write-back, and consumes the *M signals that register produces.
- Drives a req/ack data-bus, stalling upstream on wait states and timing out hung accesses.
- Formats store data and byte enables, extracts and extends load data.
- Registers the MEM/WB result.

Parameters:
MAX_WAIT, 16, number of WAIT-state cycles without dAck before the access is aborted; legal range 1..255.

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  synchronous, active-low reset
regWriteM  in  1  instruction writes rd
memWriteM  in  1  store
ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
funct3M  in  3  access size/sign
aluResultM  in  32  effective address or ALU result
writeDataM  in  32  store data (rs2)
PCPlus4M  in  32  link value
rdM  in  5  destination register
dReq  out  1  bus request
dWe  out  1  1 = write
dAddr  out  32  word-aligned address, {aluResultM[31:2],2'b00}
dWdata  out  32  lane-replicated store data
dBe  out  4  byte enables
dAck  in  1  access complete; dRdata valid in the same cycle
dRdata  in  32  read data
stallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
regWriteW  out  1  write-back enable
rdW  out  5  write-back register
ResultW  out  32  write-back data
busErr  out  1  sticky timeout flag
misalignM  out  1  misaligned-access pulse; tied 0 unless MISALIGN_TRAP_EN

Behaviour:
- Definition: memOp = memWriteM | (ResultSrcM==01). Bubbles arrive as regWriteM=0, memWriteM=0, ResultSrcM=00.
- FSM states: IDLE, WAIT. waitCnt is $clog2(MAX_WAIT+1) bits wide.
- IDLE, memOp: dReq=1 combinationally in the same cycle.
  - dAck=1: zero-wait completion, stallM=0, stay IDLE.
  - Otherwise: stallM=1, go to WAIT, waitCnt<=0.
- WAIT: dReq=1 with all bus fields held stable.
  - dAck: complete, stallM=0, go to IDLE.
  - No dAck and waitCnt==MAX_WAIT-1: abort. busErr<=1, stallM=0, load result forced to 0 and regWriteW suppressed, go to IDLE.
  - Otherwise: stallM=1, waitCnt increments.
- dWe=memWriteM. dAck is ignored when dReq=0. EX/MEM must hold its outputs while stallM=1.
- Store formatting, off=aluResultM[1:0]:
  - SB (000): dBe=0001<<off, dWdata={4{wd[7:0]}}.
  - SH (001): dBe=off[1]?1100:0011, dWdata={2{wd[15:0]}}.
  - SW (010) and other funct3 values: dBe=1111, dWdata=wd.
  - Loads drive dBe=1111.
- Load extraction from dRdata, in the ack cycle:
  - LB (000) / LBU (100): byte at off, sign- or zero-extended.
  - LH (001) / LHU (101): half at off[1], sign- or zero-extended.
  - LW and other funct3 values: full word.
- Write-back register, updated every cycle:
  - stallM=0: regWriteW<=regWriteM & ~abort, rdW<=rdM. ResultW<=ALU, load data, or PCPlus4M according to ResultSrcM (11 selects ALU).
  - stallM=1: regWriteW<=0; rdW and ResultW hold.
  - Latency: result is visible 1 cycle after completion.
- busErr clears only on reset.
- Reset (RESETn=0 at posedge):
  - State IDLE, waitCnt=0, regWriteW=0, rdW=0, ResultW=0, busErr=0.
  - While RESETn=0, dReq and stallM are forced to 0.
  - Reset during WAIT abandons the access; no write-back occurs.
- Back-to-back memOps: the next access issues in the cycle after the previous one completes.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: an access is misaligned when half off[0]=1, or word off!=00.
  - No bus request is issued for it, and stallM=0.
  - misalignM=1 for that cycle.
  - Write-back: regWriteW<=0 next cycle, busErr unaffected.
- Undefined: misalignM tied 0; low address bits ignored as in the Behaviour section (half uses off[1], word ignores off).

Test Plan:
1. LW at 0x100, dAck in the request cycle, dRdata=0xDEADBEEF, rdM=5 -> stallM stays 0, dAddr=0x100, dBe=1111; next cycle regWriteW=1, rdW=5, ResultW=0xDEADBEEF.
2. LB then LBU at 0x103, zero-wait, dRdata=0x80112233 -> ResultW=0xFFFFFF80, then 0x00000080.
3. SH at 0x202, writeDataM=0x1234ABCD, dAck after 3 WAIT cycles -> dAddr=0x200, dBe=1100, dWdata=0xABCDABCD, dWe=1, stallM high 3 cycles, regWriteW=0 throughout.
4. MAX_WAIT=4, LW with dAck never asserted -> dReq high 5 cycles, stallM high 4, busErr=1 from the following cycle, regWriteW=0.
5. RESETn=0 during WAIT -> next cycle dReq=0, stallM=0, regWriteW=0, ResultW=0, busErr=0; a following load completes normally.
6. MISALIGN_TRAP_EN defined: LW at 0x102 -> misalignM=1 for one cycle, dReq=0, stallM=0, regWriteW=0 next cycle. Undefined: the same access issues with dAddr=0x100.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory stage: req/ack data-bus master with wait-state stall and timeout, store/load formatting, MEM/WB register.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        regWriteM,
  input  logic        memWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluResultM,
  input  logic [31:0] writeDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  rdM,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [31:0] dWdata,
  output logic [3:0]  dBe,
  input  logic        dAck,
  input  logic [31:0] dRdata,
  output logic        stallM,
  output logic        regWriteW,
  output logic [4:0]  rdW,
  output logic [31:0] ResultW,
  output logic        busErr,
  output logic        misalignM
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait_cnt;

  logic        w_mem_op;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic        w_dreq;
  logic        w_stall;
  logic        w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_result;

  assign w_mem_op = memWriteM | (ResultSrcM == 2'b01);
  assign w_off    = aluResultM[1:0];

`ifdef MISALIGN_TRAP_EN
  logic w_bad_align;
  assign w_bad_align = ((funct3M[1:0] == 2'b01) && w_off[0]) ||
                       ((funct3M[1:0] == 2'b10) && (w_off != 2'b00));
  // Only a fresh access in IDLE can be trapped; WAIT always holds an aligned one.
  assign w_misalign  = RESETn && (r_state == S_IDLE) && w_mem_op && w_bad_align;
`else
  assign w_misalign  = 1'b0;
`endif

  assign misalignM = w_misalign;

  // FSM: state register, also owns the wait-state counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op && !w_misalign && !dAck) w_next = S_WAIT;
      S_WAIT: if (dAck || w_abort) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs; reset masks the request and the stall.
  always_comb begin
    w_dreq  = 1'b0;
    w_stall = 1'b0;
    w_abort = 1'b0;
    if (RESETn) begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op && !w_misalign) begin
            w_dreq  = 1'b1;
            w_stall = !dAck;
          end
        end
        S_WAIT: begin
          w_dreq = 1'b1;
          if (!dAck) begin
            if (r_wait_cnt == LAST_CNT) w_abort = 1'b1;
            else                        w_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dReq   = w_dreq;
  assign stallM = w_stall;
  assign dWe    = memWriteM;
  assign dAddr  = {aluResultM[31:2], 2'b00};
  assign dBe    = w_be;
  assign dWdata = w_wdata;

  // Store formatting: replicate data across lanes, select lanes with byte enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeDataM;
    case (funct3M)
      3'b000: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{writeDataM[7:0]}};
      end
      3'b001: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeDataM[15:0]}};
      end
      default: ;
    endcase
    if (!memWriteM) w_be = 4'b1111;
  end

  always_comb begin
    w_byte = dRdata[7:0];
    case (w_off)
      2'b00: w_byte = dRdata[7:0];
      2'b01: w_byte = dRdata[15:8];
      2'b10: w_byte = dRdata[23:16];
      2'b11: w_byte = dRdata[31:24];
      default: ;
    endcase
  end

  assign w_half = w_off[1] ? dRdata[31:16] : dRdata[15:0];

  // Load extraction; an aborted access returns zero.
  always_comb begin
    w_load_data = dRdata;
    case (funct3M)
      3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100: w_load_data = {24'd0, w_byte};
      3'b001: w_load_data = {{16{w_half[15]}}, w_half};
      3'b101: w_load_data = {16'd0, w_half};
      default: ;
    endcase
    if (w_abort || w_misalign) w_load_data = '0;
  end

  always_comb begin
    w_result = aluResultM;
    case (ResultSrcM)
      2'b01:   w_result = w_load_data;
      2'b10:   w_result = PCPlus4M;
      default: w_result = aluResultM;
    endcase
  end

  // MEM/WB register: a stalled cycle injects a bubble and holds the payload.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      regWriteW <= 1'b0;
      rdW       <= '0;
      ResultW   <= '0;
    end else if (w_stall) begin
      regWriteW <= 1'b0;
    end else begin
      regWriteW <= regWriteM & ~w_abort & ~w_misalign;
      rdW       <= rdM;
      ResultW   <= w_result;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn)      busErr <= 1'b0;
    else if (w_abort) busErr <= 1'b1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (MAX_WAIT=4); honours MISALIGN_TRAP_EN when defined.
module tb_mem_stage;

  logic        CLK;
  logic        RESETn;
  logic        regWriteM;
  logic        memWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] aluResultM;
  logic [31:0] writeDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  rdM;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dBe;
  logic        dAck;
  logic [31:0] dRdata;
  logic        stallM;
  logic        regWriteW;
  logic [4:0]  rdW;
  logic [31:0] ResultW;
  logic        busErr;
  logic        misalignM;

  int tests_run;
  int tests_failed;

  mem_stage #(.MAX_WAIT(4)) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .regWriteM  (regWriteM),
    .memWriteM  (memWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .aluResultM (aluResultM),
    .writeDataM (writeDataM),
    .PCPlus4M   (PCPlus4M),
    .rdM        (rdM),
    .dReq       (dReq),
    .dWe        (dWe),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .dBe        (dBe),
    .dAck       (dAck),
    .dRdata     (dRdata),
    .stallM     (stallM),
    .regWriteW  (regWriteW),
    .rdW        (rdW),
    .ResultW    (ResultW),
    .busErr     (busErr),
    .misalignM  (misalignM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] rd);
    regWriteM  = rw;
    memWriteM  = mw;
    ResultSrcM = rs;
    funct3M    = f3;
    aluResultM = a;
    writeDataM = wd;
    PCPlus4M   = pc4;
    rdM        = rd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0000_5A5A, 32'h0, 32'h0, 5'd0);
    dAck = 1'b0;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    bubble();
    step();
    step();
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd5);
    sample();
    tests_run++;
    if ({dReq, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_gate: dReq,stallM got %b want 00", {dReq, stallM});
    end
    tests_run++;
    if ({regWriteW, rdW, ResultW, busErr, misalignM} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_state: regWriteW=%b rdW=%0d ResultW=%h busErr=%b misalignM=%b want all 0",
               regWriteW, rdW, ResultW, busErr, misalignM);
    end
    step();
    RESETn = 1'b1;
    bubble();
  endtask

  task automatic test_load_word();
    step();
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd5);
    dAck   = 1'b1;
    dRdata = 32'hDEAD_BEEF;
    sample();
    tests_run++;
    if ({dReq, dWe, stallM, dBe, dAddr} !== {1'b1, 1'b0, 1'b0, 4'b1111, 32'h100}) begin
      tests_failed++;
      $display("FAIL lw_bus: dReq=%b dWe=%b stallM=%b dBe=%b dAddr=%h want 1 0 0 1111 00000100",
               dReq, dWe, stallM, dBe, dAddr);
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({regWriteW, rdW, ResultW} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL lw_wb: regWriteW=%b rdW=%0d ResultW=%h want 1 5 deadbeef", regWriteW, rdW, ResultW);
    end
  endtask

  // Back-to-back zero-wait loads; each result is checked while the next load is on the bus.
  task automatic test_load_extract();
    logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b011};
    logic [31:0] adrs [7] = '{32'h103, 32'h103, 32'h101, 32'h202, 32'h202, 32'h200, 32'h200};
    logic [31:0] rdat [7] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h8001_7FFF,
                              32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
    logic [31:0] exps [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0022, 32'hFFFF_8001,
                              32'h0000_8001, 32'h0000_7FFF, 32'h8001_7FFF};
    for (int i = 0; i <= 7; i++) begin
      step();
      if (i < 7) begin
        drive(1'b1, 1'b0, 2'b01, f3s[i], adrs[i], 32'h0, 32'h0, 5'(i + 8));
        dAck   = 1'b1;
        dRdata = rdat[i];
      end else begin
        bubble();
      end
      sample();
      if (i < 7) begin
        tests_run++;
        if ({dReq, stallM} !== 2'b10) begin
          tests_failed++;
          $display("FAIL load_issue[%0d]: dReq,stallM got %b want 10", i, {dReq, stallM});
        end
      end
      if (i > 0) begin
        tests_run++;
        if ({regWriteW, rdW, ResultW} !== {1'b1, 5'(i + 7), exps[i-1]}) begin
          tests_failed++;
          $display("FAIL load_data[%0d]: regWriteW=%b rdW=%0d ResultW=%h want 1 %0d %h",
                   i - 1, regWriteW, rdW, ResultW, i + 7, exps[i-1]);
        end
      end
    end
  endtask

  task automatic test_store_wait();
    step();
    drive(1'b0, 1'b1, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 5'd0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      dAck = (c == 3);
      sample();
      tests_run++;
      if ({dReq, dWe, dBe, dAddr, dWdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCD_ABCD}) begin
        tests_failed++;
        $display("FAIL sh_bus[%0d]: dReq=%b dWe=%b dBe=%b dAddr=%h dWdata=%h want 1 1 1100 00000200 abcdabcd",
                 c, dReq, dWe, dBe, dAddr, dWdata);
      end
      tests_run++;
      if ({stallM, regWriteW, ResultW} !== {(c != 3), 1'b0, 32'h0000_5A5A}) begin
        tests_failed++;
        $display("FAIL sh_stall[%0d]: stallM=%b regWriteW=%b ResultW=%h want %b 0 00005a5a",
                 c, stallM, regWriteW, ResultW, (c != 3));
      end
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({regWriteW, ResultW, dReq} !== {1'b0, 32'h202, 1'b0}) begin
      tests_failed++;
      $display("FAIL sh_done: regWriteW=%b ResultW=%h dReq=%b want 0 00000202 0", regWriteW, ResultW, dReq);
    end
  endtask

  task automatic test_store_formats();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b111};
    logic [31:0] adrs [5] = '{32'h201, 32'h203, 32'h200, 32'h204, 32'h208};
    logic [31:0] wds  [5] = '{32'h0000_00A5, 32'h1234_567F, 32'h1234_ABCD, 32'hCAFE_F00D, 32'h0BAD_CAFE};
    logic [3:0]  ebe  [5] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] ewd  [5] = '{32'hA5A5_A5A5, 32'h7F7F_7F7F, 32'hABCD_ABCD, 32'hCAFE_F00D, 32'h0BAD_CAFE};
    logic [31:0] eadr [5] = '{32'h200, 32'h200, 32'h200, 32'h204, 32'h208};
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b0, 1'b1, 2'b00, f3s[i], adrs[i], wds[i], 32'h0, 5'd0);
      dAck = 1'b1;
      sample();
      tests_run++;
      if ({dReq, dWe, stallM, dBe, dAddr, dWdata} !== {1'b1, 1'b1, 1'b0, ebe[i], eadr[i], ewd[i]}) begin
        tests_failed++;
        $display("FAIL store_fmt[%0d]: dReq=%b dWe=%b stallM=%b dBe=%b dAddr=%h dWdata=%h want 1 1 0 %b %h %h",
                 i, dReq, dWe, stallM, dBe, dAddr, dWdata, ebe[i], eadr[i], ewd[i]);
      end
    end
    step();
    bubble();
  endtask

  // Non-memory ops with a stray dAck: no request, no stall, result by ResultSrcM.
  task automatic test_writeback_sel();
    logic [1:0]  rss  [3] = '{2'b00, 2'b11, 2'b10};
    logic [31:0] exps [3] = '{32'h1111_1111, 32'h2222_2222, 32'h0000_0444};
    logic [31:0] alus [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        drive(1'b1, 1'b0, rss[i], 3'b010, alus[i], 32'h0, 32'h444, 5'(i + 1));
        dAck = 1'b1;
      end else begin
        bubble();
      end
      sample();
      if (i < 3) begin
        tests_run++;
        if ({dReq, stallM} !== 2'b00) begin
          tests_failed++;
          $display("FAIL wb_nomem[%0d]: dReq,stallM got %b want 00", i, {dReq, stallM});
        end
      end
      if (i > 0) begin
        tests_run++;
        if ({regWriteW, rdW, ResultW} !== {1'b1, 5'(i), exps[i-1]}) begin
          tests_failed++;
          $display("FAIL wb_sel[%0d]: regWriteW=%b rdW=%0d ResultW=%h want 1 %0d %h",
                   i - 1, regWriteW, rdW, ResultW, i, exps[i-1]);
        end
      end
      step();
    end
    bubble();
  endtask

  task automatic test_timeout();
    step();
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd10);
    dAck   = 1'b0;
    dRdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      sample();
      tests_run++;
      if ({dReq, stallM, busErr, regWriteW} !== {1'b1, (c < 4), 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL timeout_cyc[%0d]: dReq=%b stallM=%b busErr=%b regWriteW=%b want 1 %b 0 0",
                 c, dReq, stallM, busErr, regWriteW, (c < 4));
      end
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({busErr, regWriteW, ResultW, dReq, stallM} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_abort: busErr=%b regWriteW=%b ResultW=%h dReq=%b stallM=%b want 1 0 00000000 0 0",
               busErr, regWriteW, ResultW, dReq, stallM);
    end
    step();
    sample();
    tests_run++;
    if (busErr !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: busErr got %b want 1", busErr);
    end
  endtask

  task automatic test_reset_in_wait();
    step();
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd11);
    dAck = 1'b0;
    step();
    sample();
    tests_run++;
    if (stallM !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstwait_pre: stallM got %b want 1", stallM);
    end
    step();
    RESETn = 1'b0;
    sample();
    tests_run++;
    if ({dReq, stallM} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstwait_gate: dReq,stallM got %b want 00", {dReq, stallM});
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({regWriteW, rdW, ResultW, busErr, dReq, stallM} !== 41'h0) begin
      tests_failed++;
      $display("FAIL rstwait_state: regWriteW=%b rdW=%0d ResultW=%h busErr=%b dReq=%b stallM=%b want all 0",
               regWriteW, rdW, ResultW, busErr, dReq, stallM);
    end
    step();
    RESETn = 1'b1;
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h104, 32'h0, 32'h0, 5'd12);
    step();
    dAck   = 1'b1;
    dRdata = 32'h1357_9BDF;
    sample();
    tests_run++;
    if ({dReq, stallM, dAddr} !== {1'b1, 1'b0, 32'h104}) begin
      tests_failed++;
      $display("FAIL rstwait_issue: dReq=%b stallM=%b dAddr=%h want 1 0 00000104", dReq, stallM, dAddr);
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({regWriteW, rdW, ResultW} !== {1'b1, 5'd12, 32'h1357_9BDF}) begin
      tests_failed++;
      $display("FAIL rstwait_load: regWriteW=%b rdW=%0d ResultW=%h want 1 12 13579bdf", regWriteW, rdW, ResultW);
    end
  endtask

  task automatic test_misalign();
    step();
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h0, 5'd13);
`ifdef MISALIGN_TRAP_EN
    dAck = 1'b0;
    sample();
    tests_run++;
    if ({misalignM, dReq, stallM} !== 3'b100) begin
      tests_failed++;
      $display("FAIL misalign_lw: misalignM,dReq,stallM got %b want 100", {misalignM, dReq, stallM});
    end
    step();
    drive(1'b0, 1'b1, 2'b00, 3'b001, 32'h203, 32'h0, 32'h0, 5'd0);
    sample();
    tests_run++;
    if ({misalignM, dReq, stallM, regWriteW, busErr} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL misalign_sh: misalignM,dReq,stallM,regWriteW,busErr got %b want 10000",
               {misalignM, dReq, stallM, regWriteW, busErr});
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({misalignM, regWriteW, busErr} !== 3'b000) begin
      tests_failed++;
      $display("FAIL misalign_after: misalignM,regWriteW,busErr got %b want 000", {misalignM, regWriteW, busErr});
    end
`else
    dAck   = 1'b1;
    dRdata = 32'h0BAD_F00D;
    sample();
    tests_run++;
    if ({misalignM, dReq, stallM, dAddr} !== {1'b0, 1'b1, 1'b0, 32'h100}) begin
      tests_failed++;
      $display("FAIL misalign_off: misalignM=%b dReq=%b stallM=%b dAddr=%h want 0 1 0 00000100",
               misalignM, dReq, stallM, dAddr);
    end
    step();
    bubble();
    sample();
    tests_run++;
    if ({regWriteW, rdW, ResultW} !== {1'b1, 5'd13, 32'h0BAD_F00D}) begin
      tests_failed++;
      $display("FAIL misalign_off_wb: regWriteW=%b rdW=%0d ResultW=%h want 1 13 0badf00d", regWriteW, rdW, ResultW);
    end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    dAck         = 1'b0;
    dRdata       = 32'h0;
    test_reset();
    test_load_word();
    test_load_extract();
    test_store_wait();
    test_store_formats();
    test_writeback_sel();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
